// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the branch predictor slice.
//   BP_SNT/BP_WNT/BP_WT/BP_ST : 2-bit direction counter encodings
//   ADDR_W_DEF                : default PC width (word-addressed)
//   sat_inc2/sat_dec2         : saturating step of a 2-bit direction counter
package cpu_pkg;

   localparam int unsigned ADDR_W_DEF = 16;

   localparam logic [1:0] BP_SNT = 2'b00;
   localparam logic [1:0] BP_WNT = 2'b01;
   localparam logic [1:0] BP_WT  = 2'b10;
   localparam logic [1:0] BP_ST  = 2'b11;

   function automatic logic [1:0] sat_inc2(input logic [1:0] c);
      return (c == BP_ST) ? BP_ST : c + 2'd1;
   endfunction

   function automatic logic [1:0] sat_dec2(input logic [1:0] c);
      return (c == BP_SNT) ? BP_SNT : c - 2'd1;
   endfunction

endpackage

// File: rtl/sat_counter_stat.sv
// Saturating statistics counter: counts cycles with inc high, holds at all-ones.
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears count
//   inc   : count this cycle
//   count : current count
module sat_counter_stat #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (inc && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Lookup is combinational from the fetch PC; training comes from EX.
//   clk, rst_n           : clock, asynchronous active-low reset
//   lk_en, lk_pc         : fetch valid / fetch PC
//   lk_hit, lk_taken     : entry hit / predicted taken
//   lk_target            : predicted target (0 on miss)
//   up_valid, up_pc      : resolved branch present / its PC
//   up_taken, up_target  : resolved direction / target
//   up_mispred           : resolved branch was mispredicted
//   flush, freeze        : invalidate all entries / halt all updates
//   stat_hits            : saturating count of counted fetch hits
//   stat_mispreds        : saturating count of mispredictions
module branch_predictor_btb
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lk_en,
   input  logic [ADDR_W-1:0] lk_pc,
   output logic              lk_hit,
   output logic              lk_taken,
   output logic [ADDR_W-1:0] lk_target,
   input  logic              up_valid,
   input  logic [ADDR_W-1:0] up_pc,
   input  logic              up_taken,
   input  logic [ADDR_W-1:0] up_target,
   input  logic              up_mispred,
   input  logic              flush,
   input  logic              freeze,
   output logic [CNT_W-1:0]  stat_hits,
   output logic [CNT_W-1:0]  stat_mispreds
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = ADDR_W - IDX_W;

   if ((ENTRIES < 2) || ((ENTRIES & (ENTRIES - 1)) != 32'd0)) begin : g_bad_entries
      $error("branch_predictor_btb: ENTRIES must be a power of 2 and >= 2");
   end

   logic [ENTRIES-1:0] r_valid;
   logic [TAG_W-1:0]   r_tag    [ENTRIES];
   logic [ADDR_W-1:0]  r_target [ENTRIES];
   logic [1:0]         r_ctr    [ENTRIES];

   logic [IDX_W-1:0]   w_lk_idx;
   logic [TAG_W-1:0]   w_lk_tag;
   logic [IDX_W-1:0]   w_up_idx;
   logic [TAG_W-1:0]   w_up_tag;
   logic               w_up_match;
   logic               w_hit_inc;
   logic               w_misp_inc;

   assign w_lk_idx = lk_pc[IDX_W-1:0];
   assign w_lk_tag = lk_pc[ADDR_W-1:IDX_W];
   assign w_up_idx = up_pc[IDX_W-1:0];
   assign w_up_tag = up_pc[ADDR_W-1:IDX_W];

   // Lookup reads the registered table only, so a same-cycle update is not bypassed.
   always_comb begin
      lk_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
      lk_taken  = lk_hit && r_ctr[w_lk_idx][1];
      lk_target = lk_hit ? r_target[w_lk_idx] : '0;
   end

   assign w_up_match = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= BP_WNT;
         end
      end else if (flush) begin
         // Flush wins over freeze and over any same-cycle training.
         r_valid <= '0;
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            r_ctr[i] <= BP_WNT;
         end
      end else if (up_valid && !freeze) begin
         if (w_up_match) begin
            if (up_taken) begin
               r_ctr[w_up_idx]    <= sat_inc2(r_ctr[w_up_idx]);
               r_target[w_up_idx] <= up_target;
            end else begin
               r_ctr[w_up_idx] <= sat_dec2(r_ctr[w_up_idx]);
            end
         end else if (up_taken) begin
            // Only taken branches allocate; they start weakly taken.
            r_valid[w_up_idx]  <= 1'b1;
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= up_target;
            r_ctr[w_up_idx]    <= BP_WT;
         end
      end
   end

   assign w_hit_inc  = lk_en && lk_hit && !freeze;
   assign w_misp_inc = up_valid && up_mispred && !freeze;

   sat_counter_stat #(.W(CNT_W)) u_stat_hits (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_hit_inc),
      .count (stat_hits)
   );

   sat_counter_stat #(.W(CNT_W)) u_stat_mispreds (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_misp_inc),
      .count (stat_mispreds)
   );

endmodule

// File: tb/tb_branch_predictor_btb.sv
module tb_branch_predictor_btb;

   localparam int unsigned AW   = 16;
   localparam int unsigned NENT = 16;
   localparam int unsigned CW   = 4;
   localparam int          CMAX = 15;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          lk_en;
   logic [AW-1:0] lk_pc;
   logic          lk_hit;
   logic          lk_taken;
   logic [AW-1:0] lk_target;
   logic          up_valid;
   logic [AW-1:0] up_pc;
   logic          up_taken;
   logic [AW-1:0] up_target;
   logic          up_mispred;
   logic          flush;
   logic          freeze;
   logic [CW-1:0] stat_hits;
   logic [CW-1:0] stat_mispreds;

   always #5 clk = ~clk;

   branch_predictor_btb #(.ADDR_W(AW), .ENTRIES(NENT), .CNT_W(CW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .lk_en         (lk_en),
      .lk_pc         (lk_pc),
      .lk_hit        (lk_hit),
      .lk_taken      (lk_taken),
      .lk_target     (lk_target),
      .up_valid      (up_valid),
      .up_pc         (up_pc),
      .up_taken      (up_taken),
      .up_target     (up_target),
      .up_mispred    (up_mispred),
      .flush         (flush),
      .freeze        (freeze),
      .stat_hits     (stat_hits),
      .stat_mispreds (stat_mispreds)
   );

   // Reference model: each slot remembers the full branch PC it holds and a
   // confidence level 0..3 (>=2 means predict taken).
   bit m_valid  [NENT];
   int m_pc     [NENT];
   int m_target [NENT];
   int m_conf   [NENT];
   int m_hits;
   int m_misp;

   typedef struct {
      bit hit;
      bit taken;
      int target;
      int hits;
      int misp;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic void model_reset();
      for (int i = 0; i < NENT; i++) begin
         m_valid[i] = 0; m_pc[i] = 0; m_target[i] = 0; m_conf[i] = 1;
      end
      m_hits = 0;
      m_misp = 0;
   endfunction

   function automatic exp_t model_lookup(int pc);
      exp_t e;
      int   s = pc % NENT;
      e.hit    = m_valid[s] && (m_pc[s] == pc);
      e.taken  = e.hit && (m_conf[s] >= 2);
      e.target = e.hit ? m_target[s] : 0;
      e.hits   = m_hits;
      e.misp   = m_misp;
      return e;
   endfunction

   function automatic void model_step(bit en, bit hit, bit uv, int upc, bit ut, int utgt,
                                      bit um, bit fl, bit fz);
      int s = upc % NENT;
      if (!fz && en && hit && m_hits < CMAX) m_hits++;
      if (!fz && uv && um && m_misp < CMAX) m_misp++;
      if (fl) begin
         for (int i = 0; i < NENT; i++) begin
            m_valid[i] = 0; m_conf[i] = 1;
         end
      end else if (uv && !fz) begin
         if (m_valid[s] && m_pc[s] == upc) begin
            if (ut) begin
               m_conf[s]   = (m_conf[s] < 3) ? m_conf[s] + 1 : 3;
               m_target[s] = utgt;
            end else begin
               m_conf[s] = (m_conf[s] > 0) ? m_conf[s] - 1 : 0;
            end
         end else if (ut) begin
            m_valid[s] = 1; m_pc[s] = upc; m_target[s] = utgt; m_conf[s] = 2;
         end
      end
   endfunction

   // One fetch/train cycle: drive, record expectation, advance the model.
   task automatic cycle(bit en, int lpc, bit uv, int upc, bit ut, int utgt, bit um,
                        bit fl, bit fz);
      exp_t e;
      @(negedge clk);
      lk_en = en; lk_pc = AW'(lpc);
      up_valid = uv; up_pc = AW'(upc); up_taken = ut; up_target = AW'(utgt);
      up_mispred = um; flush = fl; freeze = fz;
      e = model_lookup(lpc);
      sb_q.push_back(e);
      model_step(en, e.hit, uv, upc, ut, utgt, um, fl, fz);
   endtask

   task automatic look(int pc);
      cycle(1, pc, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic train(int lpc, int upc, bit ut, int utgt);
      cycle(1, lpc, 1, upc, ut, utgt, 0, 0, 0);
   endtask

   // Reset is asserted between edges while an update is being presented.
   task automatic pulse_reset(int lpc);
      @(negedge clk);
      lk_en = 1; lk_pc = AW'(lpc);
      up_valid = 1; up_pc = AW'(lpc); up_taken = 1; up_target = 16'h0abc; up_mispred = 1;
      #1 rst_n = 1'b0;
      model_reset();
      sb_q.push_back(model_lookup(lpc));
      @(negedge clk);
      up_valid = 0; up_mispred = 0;
      sb_q.push_back(model_lookup(lpc));
      #1 rst_n = 1'b1;
   endtask

   task automatic chk(string name, int act, int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: every cycle's lookup/stat outputs are sampled mid-low-phase.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("lk_hit",        int'(lk_hit),        int'(e.hit));
            chk("lk_taken",      int'(lk_taken),      int'(e.taken));
            chk("lk_target",     int'(lk_target),     e.target);
            chk("stat_hits",     int'(stat_hits),     e.hits);
            chk("stat_mispreds", int'(stat_mispreds), e.misp);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pc_u, pc_l;
      lk_en = 0; lk_pc = '0; up_valid = 0; up_pc = '0; up_taken = 0;
      up_target = '0; up_mispred = 0; flush = 0; freeze = 0;
      rst_n = 1'b0;
      model_reset();
      #12 rst_n = 1'b1;

      // Reset state
      look(16'h0010);
      // Allocate then hit
      train(16'h0010, 16'h0010, 1, 16'h0040);
      look(16'h0010);
      // Walk the counter down, saturate low, then up, saturate high
      for (int i = 0; i < 3; i++) train(16'h0010, 16'h0010, 0, 16'h0099);
      for (int i = 0; i < 4; i++) train(16'h0010, 16'h0010, 1, 16'h0040);
      look(16'h0010);
      // Alias on index 0
      look(16'h0020);
      train(16'h0010, 16'h0020, 1, 16'h0077);
      look(16'h0010);
      look(16'h0020);
      // Not-taken miss never allocates
      train(16'h0031, 16'h0031, 0, 16'h0011);
      look(16'h0031);
      // Same-cycle update and lookup: old view now, new view next cycle
      train(16'h0020, 16'h0020, 1, 16'h0055);
      look(16'h0020);
      // Flush with a competing update
      cycle(1, 16'h0020, 1, 16'h0042, 1, 16'h0123, 0, 1, 0);
      look(16'h0020);
      look(16'h0042);
      // Mispredict statistic saturation
      for (int i = 0; i < 20; i++) cycle(1, 16'h0005, 1, 16'h0005, 0, 0, 1, 0, 0);
      // Freeze blocks a taken allocation and stats
      cycle(1, 16'h0033, 1, 16'h0033, 1, 16'h0200, 1, 0, 1);
      look(16'h0033);
      // Flush still acts under freeze
      train(16'h0034, 16'h0034, 1, 16'h0300);
      look(16'h0034);
      cycle(1, 16'h0034, 0, 0, 0, 0, 0, 1, 1);
      look(16'h0034);
      // Reset mid-stream
      train(16'h0036, 16'h0036, 1, 16'h0400);
      look(16'h0036);
      pulse_reset(16'h0036);
      look(16'h0036);

      // Randomised traffic over a small PC set so aliasing and reuse are common
      for (int i = 0; i < 400; i++) begin
         pc_u = ($urandom_range(0, 2) << 4) | $urandom_range(0, 3);
         pc_l = ($urandom_range(0, 2) << 4) | $urandom_range(0, 3);
         cycle($urandom_range(0, 9) < 8, pc_l,
               $urandom_range(0, 9) < 6, pc_u,
               $urandom_range(0, 1) == 1, $urandom_range(0, 16'hffff),
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 39) == 0,
               $urandom_range(0, 9) == 0);
         if (i == 200) pulse_reset(pc_l);
      end

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
      #5;
      chk("scoreboard_drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
